// File: rtl/ght_cam_mt.sv
// Thread-aware CAM of recently written GHT indices: NRD registered parallel lookups,
// round-robin allocation with duplicate suppression, and per-thread flush.
module ght_cam_mt #(
    parameter  int ADDR_W = 13,
    parameter  int DEPTH  = 32,
    parameter  int NRD    = 4,
    parameter  int THR_W  = 1,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read_clkEn,
    input  logic [NRD*ADDR_W-1:0]   read_addr,
    input  logic [NRD*THR_W-1:0]    read_thread,
    output logic [NRD-1:0]          read_hit,
    output logic [NRD*IDX_W-1:0]    read_idx,
    input  logic [ADDR_W-1:0]       write_addr,
    input  logic                    write_wen,
    input  logic [THR_W-1:0]        write_thread,
    output logic                    write_dup,
    input  logic                    except,
    input  logic [THR_W-1:0]        except_thread,
    output logic [IDX_W:0]          count,
    output logic                    full
);

    logic [DEPTH-1:0]  valid;
    logic [THR_W-1:0]  ent_thr  [DEPTH];
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [IDX_W-1:0]  wrtpos;

    logic [NRD-1:0]       hit_p0;
    logic [NRD*IDX_W-1:0] idx_p0;
    logic                 dup_p0;
    logic                 flush_wr;
    logic                 accept;
    logic                 alloc;

    // Lookup against pre-edge contents; scanning downward leaves the lowest match.
    always_comb begin
        hit_p0 = '0;
        idx_p0 = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int e = DEPTH - 1; e >= 0; e--) begin
                if (valid[e] &&
                    ent_addr[e] == read_addr[p*ADDR_W +: ADDR_W] &&
                    ent_thr[e]  == read_thread[p*THR_W +: THR_W]) begin
                    hit_p0[p]                 = 1'b1;
                    idx_p0[p*IDX_W +: IDX_W]  = IDX_W'(e);
                end
            end
            if (except && except_thread == read_thread[p*THR_W +: THR_W]) begin
                hit_p0[p]                = 1'b0;
                idx_p0[p*IDX_W +: IDX_W] = '0;
            end
        end
    end

    always_comb begin
        dup_p0 = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (valid[e] && ent_addr[e] == write_addr && ent_thr[e] == write_thread)
                dup_p0 = 1'b1;
        end
    end

    // A flush of the writing thread kills the write outright.
    assign flush_wr = except && (except_thread == write_thread);
    assign accept   = write_wen && !flush_wr;
    assign alloc    = accept && !dup_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= '0;
            wrtpos    <= '0;
            read_hit  <= '0;
            read_idx  <= '0;
            write_dup <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                ent_thr[e]  <= '0;
                ent_addr[e] <= '0;
            end
        end else begin
            if (read_clkEn) begin
                read_hit <= hit_p0;
                read_idx <= idx_p0;
            end
            if (write_wen)
                write_dup <= accept && dup_p0;
            for (int e = 0; e < DEPTH; e++) begin
                if (except && ent_thr[e] == except_thread)
                    valid[e] <= 1'b0;
            end
            // Placed after the flush loop so a cross-thread allocation survives it.
            if (alloc) begin
                valid[wrtpos]    <= 1'b1;
                ent_thr[wrtpos]  <= write_thread;
                ent_addr[wrtpos] <= write_addr;
                wrtpos           <= wrtpos + IDX_W'(1);
            end
        end
    end

    always_comb begin
        count = '0;
        for (int e = 0; e < DEPTH; e++)
            count = count + (IDX_W+1)'(valid[e]);
    end

    assign full = (count == (IDX_W+1)'(DEPTH));

endmodule

// File: tb/tb_ght_cam_mt.sv
// Randomised and directed bench for ght_cam_mt against an array-based reference model.
module tb_ght_cam_mt;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 32;
    localparam int NRD    = 4;
    localparam int THR_W  = 1;
    localparam int IDX_W  = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  read_clkEn;
    logic [NRD*ADDR_W-1:0] read_addr;
    logic [NRD*THR_W-1:0]  read_thread;
    logic [NRD-1:0]        read_hit;
    logic [NRD*IDX_W-1:0]  read_idx;
    logic [ADDR_W-1:0]     write_addr;
    logic                  write_wen;
    logic [THR_W-1:0]      write_thread;
    logic                  write_dup;
    logic                  except;
    logic [THR_W-1:0]      except_thread;
    logic [IDX_W:0]        count;
    logic                  full;

    ght_cam_mt #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD), .THR_W(THR_W)) dut (
        .clk(clk), .rst_n(rst_n), .read_clkEn(read_clkEn), .read_addr(read_addr),
        .read_thread(read_thread), .read_hit(read_hit), .read_idx(read_idx),
        .write_addr(write_addr), .write_wen(write_wen), .write_thread(write_thread),
        .write_dup(write_dup), .except(except), .except_thread(except_thread),
        .count(count), .full(full)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the CAM as plain arrays of entries plus a RR pointer.
    bit mv [DEPTH];
    int mt [DEPTH];
    int ma [DEPTH];
    int mpos;
    bit e_hit [NRD];
    int e_idx [NRD];
    bit e_dup;

    function automatic void model_reset();
        for (int e = 0; e < DEPTH; e++) begin
            mv[e] = 0; mt[e] = 0; ma[e] = 0;
        end
        mpos = 0;
        for (int p = 0; p < NRD; p++) begin
            e_hit[p] = 0; e_idx[p] = 0;
        end
        e_dup = 0;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int e = 0; e < DEPTH; e++) c += mv[e];
        return c;
    endfunction

    function automatic logic [NRD*ADDR_W-1:0] ra4(input int a0, a1, a2, a3);
        return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    function automatic logic [NRD*THR_W-1:0] rt4(input int t0, t1, t2, t3);
        return {THR_W'(t3), THR_W'(t2), THR_W'(t1), THR_W'(t0)};
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input logic ren, input logic [NRD*ADDR_W-1:0] ra,
                       input logic [NRD*THR_W-1:0] rt, input logic wen,
                       input int wa, input int wt, input logic ex, input int et);
        logic [NRD-1:0]       eh;
        logic [NRD*IDX_W-1:0] ei;
        bit                   dup;
        read_clkEn    = ren;
        read_addr     = ra;
        read_thread   = rt;
        write_wen     = wen;
        write_addr    = ADDR_W'(wa);
        write_thread  = THR_W'(wt);
        except        = ex;
        except_thread = THR_W'(et);
        if (ren) begin
            for (int p = 0; p < NRD; p++) begin
                int a = int'(ra[p*ADDR_W +: ADDR_W]);
                int t = int'(rt[p*THR_W +: THR_W]);
                e_hit[p] = 0; e_idx[p] = 0;
                for (int e = DEPTH - 1; e >= 0; e--)
                    if (mv[e] && ma[e] == a && mt[e] == t) begin
                        e_hit[p] = 1; e_idx[p] = e;
                    end
                if (ex && et == t) begin
                    e_hit[p] = 0; e_idx[p] = 0;
                end
            end
        end
        dup = 0;
        for (int e = 0; e < DEPTH; e++)
            if (mv[e] && ma[e] == wa && mt[e] == wt) dup = 1;
        if (wen) e_dup = !(ex && et == wt) && dup;
        if (ex)
            for (int e = 0; e < DEPTH; e++)
                if (mt[e] == et) mv[e] = 0;
        if (wen && !(ex && et == wt) && !dup) begin
            mv[mpos] = 1; mt[mpos] = wt; ma[mpos] = wa;
            mpos = (mpos + 1) % DEPTH;
        end
        for (int p = 0; p < NRD; p++) begin
            eh[p] = e_hit[p];
            ei[p*IDX_W +: IDX_W] = IDX_W'(e_idx[p]);
        end
        @(posedge clk);
        #1;
        check("read_hit",  32'(read_hit),  32'(eh));
        check("read_idx",  32'(read_idx),  32'(ei));
        check("write_dup", 32'(write_dup), 32'(e_dup));
        check("count",     32'(count),     32'(model_count()));
        check("full",      32'(full),      32'(model_count() == DEPTH));
    endtask

    task automatic wr(input int wa, input int wt);
        cyc(1'b0, '0, '0, 1'b1, wa, wt, 1'b0, 0);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_hit",   32'(read_hit),  0);
        check("rst_idx",   32'(read_idx),  0);
        check("rst_dup",   32'(write_dup), 0);
        check("rst_count", 32'(count),     0);
        check("rst_full",  32'(full),      0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        read_clkEn = 0; read_addr = '0; read_thread = '0;
        write_addr = '0; write_wen = 0; write_thread = '0;
        except = 0; except_thread = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Write then read back; thread qualification.
        wr(12'h0A5, 0);
        cyc(1'b1, ra4(12'h0A5, 12'h0A5, 0, 0), rt4(0, 1, 0, 0), 1'b0, 0, 0, 1'b0, 0);
        check("t1_hit", 32'(read_hit[1:0]), 32'b01);
        check("t1_idx", 32'(read_idx[IDX_W-1:0]), 0);
        check("t1_cnt", 32'(count), 1);

        // Same-cycle write is not bypassed to the read.
        cyc(1'b1, ra4(12'h123, 0, 0, 0), rt4(0, 0, 0, 0), 1'b1, 12'h123, 0, 1'b0, 0);
        check("t2_nobyp", 32'(read_hit[0]), 0);
        cyc(1'b1, ra4(12'h123, 0, 0, 0), rt4(0, 0, 0, 0), 1'b0, 0, 0, 1'b0, 0);
        check("t2_next", 32'(read_hit[0]), 1);

        // Duplicate suppression and RR placement.
        do_reset();
        wr(12'h0A5, 0);
        wr(12'h0A5, 0);
        check("t3_dup", 32'(write_dup), 1);
        check("t3_cnt", 32'(count), 1);
        wr(12'h0B6, 0);
        check("t3_nodup", 32'(write_dup), 0);
        cyc(1'b1, ra4(12'h0B6, 0, 0, 0), rt4(0, 0, 0, 0), 1'b0, 0, 0, 1'b0, 0);
        check("t3_idx1", 32'(read_idx[IDX_W-1:0]), 1);

        // Wrap-around eviction when full.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) wr(12'h100 + i, 0);
        check("t4_full", 32'(full), 1);
        check("t4_cnt",  32'(count), DEPTH);
        cyc(1'b1, ra4(12'h100, 12'h101, 12'h100 + DEPTH, 12'h101 + DEPTH), rt4(0, 0, 0, 0),
            1'b0, 0, 0, 1'b0, 0);
        check("t4_hit", 32'(read_hit), 32'b1100);
        check("t4_idx", 32'(read_idx), 32'(1) << (3*IDX_W));

        // Flush thread 0 with a concurrent read and a thread-1 write.
        do_reset();
        for (int i = 0; i < 4; i++) wr(12'h10 + i, 0);
        for (int i = 0; i < 4; i++) wr(12'h20 + i, 1);
        cyc(1'b1, ra4(12'h10, 12'h20, 0, 0), rt4(0, 1, 0, 0), 1'b1, 12'h7FF, 1, 1'b1, 0);
        check("t5_hit", 32'(read_hit[1:0]), 32'b10);
        check("t5_cnt", 32'(count), 5);
        cyc(1'b1, ra4(12'h7FF, 12'h21, 12'h23, 12'h11), rt4(1, 1, 1, 0), 1'b0, 0, 0, 1'b0, 0);
        check("t5_surv", 32'(read_hit), 32'b0111);

        // Flush of the writing thread drops the write.
        wr(12'h33, 0);
        wr(12'h33, 0);
        cyc(1'b0, '0, '0, 1'b1, 12'h44, 0, 1'b1, 0);
        check("t6_drop_dup", 32'(write_dup), 0);
        check("t6_drop_cnt", 32'(count), 5);

        // Random traffic with mid-stream resets.
        for (int n = 0; n < 600; n++) begin
            logic [NRD*ADDR_W-1:0] ra;
            logic [NRD*THR_W-1:0]  rt;
            for (int p = 0; p < NRD; p++) begin
                ra[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 40));
                rt[p*THR_W +: THR_W]   = THR_W'($urandom_range(0, 1));
            end
            if (n % 200 == 199) do_reset();
            cyc($urandom_range(0, 3) != 0, ra, rt, $urandom_range(0, 2) != 0,
                $urandom_range(0, 40), $urandom_range(0, 1),
                $urandom_range(0, 15) == 0, $urandom_range(0, 1));
        end

        // After a mid-stream reset the first write lands in entry 0.
        do_reset();
        wr(12'h555, 1);
        cyc(1'b1, ra4(0, 12'h555, 0, 0), rt4(0, 1, 0, 0), 1'b0, 0, 0, 1'b0, 0);
        check("t6_rst_hit", 32'(read_hit[1]), 1);
        check("t6_rst_idx", 32'(read_idx[2*IDX_W-1:IDX_W]), 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
